// File: rtl/ysyx_041461_pipe_ctrl_pkg.sv
// Shared codes for the pipeline controller: FSM states, PC select, trap and bubble constants.
package ysyx_041461_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_MEMW = 2'd1,
    ST_TRAP = 2'd2
  } state_e;

  localparam logic [1:0]  PCSEL_SEQ    = 2'd0;
  localparam logic [1:0]  PCSEL_BRANCH = 2'd1;
  localparam logic [1:0]  PCSEL_TRAP   = 2'd2;

  localparam logic [3:0]  TRAP_NOP     = 4'd0;
  localparam logic [3:0]  TRAP_ECALL   = 4'd11;

  localparam logic [31:0] MEM_NOP      = 32'h0000_0013;
  localparam logic [31:0] WB_NOP       = 32'h0000_0013;

  localparam int MEM_TIMEOUT_DEF = 255;
  localparam int PERF_W_DEF      = 32;

  // Stage enable vector {IF,ID,EXE,MEM,WB}; flush vector {ID,EXE,MEM,WB}.
  localparam logic [4:0] EN_ALL      = 5'b11111;
  localparam logic [4:0] EN_WB_ONLY  = 5'b00001;
  localparam logic [4:0] EN_LOADUSE  = 5'b00111;
  localparam logic [4:0] EN_NO_IF    = 5'b01111;
  localparam logic [3:0] FL_NONE     = 4'b0000;
  localparam logic [3:0] FL_ALL      = 4'b1111;
  localparam logic [3:0] FL_TRAP     = 4'b1110;
  localparam logic [3:0] FL_WB       = 4'b0001;
  localparam logic [3:0] FL_EXE      = 4'b0100;
  localparam logic [3:0] FL_BRANCH   = 4'b1100;
  localparam logic [3:0] FL_ID       = 4'b1000;

endpackage

// File: rtl/ysyx_041461_pipe_ctrl_hazard_detect.sv
// Load-use hazard detection between the ID-stage sources and a load sitting in EXE.
module ysyx_041461_hazard_detect (
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_rs1_use_i,
  input  logic       id_rs2_use_i,
  input  logic       exe_valid_i,
  input  logic       exe_is_load_i,
  input  logic [4:0] exe_rd_i,
  output logic       load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit    = id_rs1_use_i & (id_rs1_i == exe_rd_i);
  assign rs2_hit    = id_rs2_use_i & (id_rs2_i == exe_rd_i);
  // x0 never carries a real dependency.
  assign load_use_o = exe_valid_i & exe_is_load_i & (exe_rd_i != 5'd0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/ysyx_041461_pipe_ctrl.sv
// Pipeline controller: stage enables/flushes, LSU wait sequencing with timeout, trap redirect.
// RUN: normal issue | MEMW: holding for LSU | TRAP: one-cycle trap redirect
module ysyx_041461_pipe_ctrl
  import ysyx_041461_pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int PERF_W      = PERF_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_ready_i,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rs2_i,
  input  logic              id_rs1_use_i,
  input  logic              id_rs2_use_i,
  input  logic              exe_valid_i,
  input  logic [4:0]        exe_rd_i,
  input  logic              exe_is_load_i,
  input  logic              exe_redirect_i,
  input  logic              mem_valid_i,
  input  logic              mem_is_mem_i,
  input  logic [3:0]        mem_trap_i,
  input  logic              lsu_ready_i,
  output logic              IFreg_enable_o,
  output logic              IDreg_enable_o,
  output logic              EXEreg_enable_o,
  output logic              MEMreg_enable_o,
  output logic              WBreg_enable_o,
  output logic              IDreg_flush_o,
  output logic              EXEreg_flush_o,
  output logic              MEMreg_flush_o,
  output logic              WBreg_flush_o,
  output logic              pc_redirect_o,
  output logic [1:0]        pc_sel_o,
  output logic              mem_timeout_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  localparam int              WAIT_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [PERF_W-1:0]   stall_q, stall_d;
  logic [4:0]          en;
  logic [3:0]          fl;
  logic                trap_hit, lsu_wait, load_use;

  ysyx_041461_hazard_detect u_hazard (
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rs1_use_i  (id_rs1_use_i),
    .id_rs2_use_i  (id_rs2_use_i),
    .exe_valid_i   (exe_valid_i),
    .exe_is_load_i (exe_is_load_i),
    .exe_rd_i      (exe_rd_i),
    .load_use_o    (load_use)
  );

  assign trap_hit = mem_valid_i & (mem_trap_i != TRAP_NOP);
  assign lsu_wait = mem_valid_i & mem_is_mem_i & ~lsu_ready_i;

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    en            = EN_ALL;
    fl            = FL_NONE;
    pc_redirect_o = 1'b0;
    pc_sel_o      = PCSEL_SEQ;
    mem_timeout_o = 1'b0;
    if (rst) begin
      fl = FL_ALL;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          // Trapping instruction keeps going into WB so the CSR update can land.
          if (trap_hit) begin
            fl      = FL_TRAP;
            state_d = ST_TRAP;
          end else if (lsu_wait) begin
            en      = EN_WB_ONLY;
            fl      = FL_WB;
            wait_d  = WAIT_W'(1);
            state_d = ST_MEMW;
          end else if (load_use) begin
            en = EN_LOADUSE;
            fl = FL_EXE;
          end else if (exe_redirect_i) begin
            fl            = FL_BRANCH;
            pc_redirect_o = 1'b1;
            pc_sel_o      = PCSEL_BRANCH;
          end else if (!ifu_ready_i) begin
            en = EN_NO_IF;
            fl = FL_ID;
          end
        end
        ST_MEMW: begin
          if (lsu_ready_i) begin
            wait_d  = '0;
            state_d = ST_RUN;
          end else if (wait_q == TIMEOUT_CNT) begin
            mem_timeout_o = 1'b1;
            fl            = FL_TRAP;
            wait_d        = '0;
            state_d       = ST_TRAP;
          end else begin
            en     = EN_WB_ONLY;
            fl     = FL_WB;
            wait_d = wait_q + 1'b1;
          end
        end
        ST_TRAP: begin
          fl            = FL_TRAP;
          pc_redirect_o = 1'b1;
          pc_sel_o      = PCSEL_TRAP;
          state_d       = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if ((!en[4] || !en[1]) && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  assign {IFreg_enable_o, IDreg_enable_o, EXEreg_enable_o, MEMreg_enable_o, WBreg_enable_o} = en;
  assign {IDreg_flush_o, EXEreg_flush_o, MEMreg_flush_o, WBreg_flush_o} = fl;
  assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_ysyx_041461_pipe_ctrl.sv
// Directed bench for the pipeline controller, with a 4-bit perf-counter instance for saturation.
module tb_ysyx_041461_pipe_ctrl;
  import ysyx_041461_pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic ifu_ready, id_rs1_use, id_rs2_use, exe_valid, exe_is_load, exe_redirect;
  logic mem_valid, mem_is_mem, lsu_ready;
  logic [4:0] id_rs1, id_rs2, exe_rd;
  logic [3:0] mem_trap;

  logic if_en, id_en, exe_en, mem_en, wb_en, id_fl, exe_fl, mem_fl, wb_fl;
  logic pc_redirect, mem_timeout;
  logic [1:0] pc_sel;
  logic [31:0] stall_cnt;

  logic s_if_en, s_id_en, s_exe_en, s_mem_en, s_wb_en, s_id_fl, s_exe_fl, s_mem_fl, s_wb_fl;
  logic s_pc_redirect, s_mem_timeout;
  logic [1:0] s_pc_sel;
  logic [3:0] s_stall_cnt;

  int checks = 0;
  int failures = 0;
  int exp_stall = 0;

  always #5 clk = ~clk;

  ysyx_041461_pipe_ctrl #(.MEM_TIMEOUT(255), .PERF_W(32)) dut (
    .clk(clk), .rst(rst), .ifu_ready_i(ifu_ready),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rs1_use_i(id_rs1_use), .id_rs2_use_i(id_rs2_use),
    .exe_valid_i(exe_valid), .exe_rd_i(exe_rd), .exe_is_load_i(exe_is_load),
    .exe_redirect_i(exe_redirect), .mem_valid_i(mem_valid), .mem_is_mem_i(mem_is_mem),
    .mem_trap_i(mem_trap), .lsu_ready_i(lsu_ready),
    .IFreg_enable_o(if_en), .IDreg_enable_o(id_en), .EXEreg_enable_o(exe_en),
    .MEMreg_enable_o(mem_en), .WBreg_enable_o(wb_en),
    .IDreg_flush_o(id_fl), .EXEreg_flush_o(exe_fl), .MEMreg_flush_o(mem_fl), .WBreg_flush_o(wb_fl),
    .pc_redirect_o(pc_redirect), .pc_sel_o(pc_sel), .mem_timeout_o(mem_timeout),
    .stall_cnt_o(stall_cnt)
  );

  ysyx_041461_pipe_ctrl #(.MEM_TIMEOUT(255), .PERF_W(4)) u_small (
    .clk(clk), .rst(rst), .ifu_ready_i(ifu_ready),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rs1_use_i(id_rs1_use), .id_rs2_use_i(id_rs2_use),
    .exe_valid_i(exe_valid), .exe_rd_i(exe_rd), .exe_is_load_i(exe_is_load),
    .exe_redirect_i(exe_redirect), .mem_valid_i(mem_valid), .mem_is_mem_i(mem_is_mem),
    .mem_trap_i(mem_trap), .lsu_ready_i(lsu_ready),
    .IFreg_enable_o(s_if_en), .IDreg_enable_o(s_id_en), .EXEreg_enable_o(s_exe_en),
    .MEMreg_enable_o(s_mem_en), .WBreg_enable_o(s_wb_en),
    .IDreg_flush_o(s_id_fl), .EXEreg_flush_o(s_exe_fl), .MEMreg_flush_o(s_mem_fl),
    .WBreg_flush_o(s_wb_fl),
    .pc_redirect_o(s_pc_redirect), .pc_sel_o(s_pc_sel), .mem_timeout_o(s_mem_timeout),
    .stall_cnt_o(s_stall_cnt)
  );

  task automatic idle();
    ifu_ready = 1'b1; lsu_ready = 1'b1;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_use = 1'b0; id_rs2_use = 1'b0;
    exe_valid = 1'b0; exe_is_load = 1'b0; exe_rd = 5'd0; exe_redirect = 1'b0;
    mem_valid = 1'b0; mem_is_mem = 1'b0; mem_trap = TRAP_NOP;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Waits 1 time unit for combinational settling, then compares {en, flush, redirect, sel, timeout}.
  task automatic chk_ctrl(input string tag, input logic [4:0] e_en, input logic [3:0] e_fl,
                          input logic e_red, input logic [1:0] e_sel, input logic e_to);
    logic [12:0] obs, exp;
    #1;
    obs = {if_en, id_en, exe_en, mem_en, wb_en, id_fl, exe_fl, mem_fl, wb_fl,
           pc_redirect, pc_sel, mem_timeout};
    exp = {e_en, e_fl, e_red, e_sel, e_to};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_load_use();
    exe_valid = 1'b1; exe_is_load = 1'b1; exe_rd = 5'd9; id_rs1 = 5'd9; id_rs1_use = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    chk_ctrl("rst_c0", 5'b11111, 4'b1111, 1'b0, PCSEL_SEQ, 1'b0);
    nxt();
    chk_ctrl("rst_c1", 5'b11111, 4'b1111, 1'b0, PCSEL_SEQ, 1'b0);
    chk_val("rst_stall", stall_cnt, 0);
    nxt();
    rst = 1'b0;
    chk_ctrl("run_idle", 5'b11111, 4'b0000, 1'b0, PCSEL_SEQ, 1'b0);
    chk_val("run_idle_stall", stall_cnt, 0);

    // load-use via rs1
    exe_valid = 1'b1; exe_is_load = 1'b1; exe_rd = 5'd5; id_rs1 = 5'd5; id_rs1_use = 1'b1;
    chk_ctrl("lu_rs1", 5'b00111, 4'b0100, 1'b0, PCSEL_SEQ, 1'b0);
    exp_stall++;
    nxt(); idle();
    chk_ctrl("lu_after", 5'b11111, 4'b0000, 1'b0, PCSEL_SEQ, 1'b0);
    chk_val("lu_stall", stall_cnt, exp_stall);
    exe_valid = 1'b1; exe_is_load = 1'b1; exe_rd = 5'd0; id_rs1 = 5'd0; id_rs1_use = 1'b1;
    chk_ctrl("lu_rd0", 5'b11111, 4'b0000, 1'b0, PCSEL_SEQ, 1'b0);
    nxt(); idle();
    exe_valid = 1'b1; exe_is_load = 1'b1; exe_rd = 5'd7; id_rs2 = 5'd7; id_rs2_use = 1'b1;
    chk_ctrl("lu_rs2", 5'b00111, 4'b0100, 1'b0, PCSEL_SEQ, 1'b0);
    exp_stall++;
    nxt(); idle();
    exe_valid = 1'b1; exe_rd = 5'd7; id_rs2 = 5'd7; id_rs2_use = 1'b1;
    chk_ctrl("no_lu_alu", 5'b11111, 4'b0000, 1'b0, PCSEL_SEQ, 1'b0);
    nxt(); idle();
    exe_valid = 1'b1; exe_is_load = 1'b1; exe_rd = 5'd3; id_rs2 = 5'd3; id_rs2_use = 1'b1;
    exe_redirect = 1'b1;
    chk_ctrl("lu_over_redir", 5'b00111, 4'b0100, 1'b0, PCSEL_SEQ, 1'b0);
    exp_stall++;

    nxt(); idle();
    exe_redirect = 1'b1; ifu_ready = 1'b0;
    chk_ctrl("redir_noifu", 5'b11111, 4'b1100, 1'b1, PCSEL_BRANCH, 1'b0);
    chk_val("redir_stall", stall_cnt, exp_stall);
    nxt(); idle();
    ifu_ready = 1'b0;
    chk_ctrl("ifu_wait", 5'b01111, 4'b1000, 1'b0, PCSEL_SEQ, 1'b0);
    exp_stall++;

    // LSU wait: three not-ready cycles then release
    nxt(); idle();
    mem_valid = 1'b1; mem_is_mem = 1'b1; lsu_ready = 1'b0;
    chk_ctrl("memw_0", 5'b00001, 4'b0001, 1'b0, PCSEL_SEQ, 1'b0);
    exp_stall++;
    nxt();
    ifu_ready = 1'b0;
    chk_ctrl("memw_1", 5'b00001, 4'b0001, 1'b0, PCSEL_SEQ, 1'b0);
    exp_stall++;
    nxt();
    ifu_ready = 1'b1; exe_redirect = 1'b1;
    chk_ctrl("memw_2", 5'b00001, 4'b0001, 1'b0, PCSEL_SEQ, 1'b0);
    exp_stall++;
    nxt();
    exe_redirect = 1'b0; lsu_ready = 1'b1;
    chk_ctrl("memw_rel", 5'b11111, 4'b0000, 1'b0, PCSEL_SEQ, 1'b0);
    chk_val("memw_stall", stall_cnt, exp_stall);
    nxt(); idle();
    ifu_ready = 1'b0;
    chk_ctrl("memw_back_run", 5'b01111, 4'b1000, 1'b0, PCSEL_SEQ, 1'b0);
    exp_stall++;

    // trap beats a same-cycle branch redirect
    nxt(); idle();
    mem_valid = 1'b1; mem_trap = TRAP_ECALL; exe_redirect = 1'b1;
    chk_ctrl("trap_hit", 5'b11111, 4'b1110, 1'b0, PCSEL_SEQ, 1'b0);
    nxt();
    exe_redirect = 1'b0;
    chk_ctrl("trap_state", 5'b11111, 4'b1110, 1'b1, PCSEL_TRAP, 1'b0);
    nxt(); idle();
    chk_ctrl("trap_back_run", 5'b11111, 4'b0000, 1'b0, PCSEL_SEQ, 1'b0);
    chk_val("trap_stall", stall_cnt, exp_stall);

    // reset while in MEMW
    mem_valid = 1'b1; mem_is_mem = 1'b1; lsu_ready = 1'b0;
    chk_ctrl("rstw_enter", 5'b00001, 4'b0001, 1'b0, PCSEL_SEQ, 1'b0);
    nxt();
    rst = 1'b1;
    chk_ctrl("rstw_rst", 5'b11111, 4'b1111, 1'b0, PCSEL_SEQ, 1'b0);
    nxt(); idle();
    rst = 1'b0;
    chk_ctrl("rstw_run", 5'b11111, 4'b0000, 1'b0, PCSEL_SEQ, 1'b0);
    exp_stall = 0;
    chk_val("rstw_stall", stall_cnt, exp_stall);
    chk_val("rstw_stall_small", {28'd0, s_stall_cnt}, 0);

    // saturation of the 4-bit counter
    for (int i = 0; i < 15; i++) begin
      set_load_use();
      nxt(); idle();
      exp_stall++;
    end
    #1;
    chk_val("sat_small_15", {28'd0, s_stall_cnt}, 15);
    set_load_use();
    nxt(); idle();
    exp_stall++;
    set_load_use();
    nxt(); idle();
    exp_stall++;
    #1;
    chk_val("sat_small_hold", {28'd0, s_stall_cnt}, 15);
    chk_val("sat_large", stall_cnt, exp_stall);

    // LSU never ready -> timeout
    mem_valid = 1'b1; mem_is_mem = 1'b1; lsu_ready = 1'b0;
    chk_ctrl("to_enter", 5'b00001, 4'b0001, 1'b0, PCSEL_SEQ, 1'b0);
    exp_stall++;
    for (int i = 1; i <= 254; i++) begin
      nxt();
      chk_ctrl("to_hold", 5'b00001, 4'b0001, 1'b0, PCSEL_SEQ, 1'b0);
      exp_stall++;
    end
    nxt();
    chk_ctrl("to_pulse", 5'b11111, 4'b1110, 1'b0, PCSEL_SEQ, 1'b1);
    nxt(); idle();
    chk_ctrl("to_trap", 5'b11111, 4'b1110, 1'b1, PCSEL_TRAP, 1'b0);
    nxt();
    chk_ctrl("to_back_run", 5'b11111, 4'b0000, 1'b0, PCSEL_SEQ, 1'b0);
    chk_val("to_stall", stall_cnt, exp_stall);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
